// File: rtl/wbm_arbiter_pkg.sv
// wbm_arbiter_pkg: shared widths and FSM state codes for the two-master Wishbone arbiter
package wbm_arbiter_pkg;

    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        WBARB_IDLE = 2'd0,
        WBARB_BUSY = 2'd1,
        WBARB_ERR  = 2'd2
    } wbarb_state_t;

endpackage

// File: rtl/wbm_arbiter_if.sv
// wbm_arbiter_if: both requesting masters, the shared wbm_* bus and the grant vector
// slave modport is the arbiter's view; master modport is the masters-plus-slave environment
interface wbm_arbiter_if
    import wbm_arbiter_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_WIDTH,
    parameter int DATA_W = WB_DATA_WIDTH
);
    logic                  m0_cycle_i, m0_strobe_i, m0_we_i;
    logic [ADDR_W-1:0]     m0_addr_i;
    logic [DATA_W-1:0]     m0_data_i;
    logic [DATA_W/8-1:0]   m0_sel_i;
    logic                  m0_ack_o, m0_err_o;
    logic                  m1_cycle_i, m1_strobe_i, m1_we_i;
    logic [ADDR_W-1:0]     m1_addr_i;
    logic [DATA_W-1:0]     m1_data_i;
    logic [DATA_W/8-1:0]   m1_sel_i;
    logic                  m1_ack_o, m1_err_o;
    logic [DATA_W-1:0]     m_data_o;
    logic                  wbm_cycle_o, wbm_strobe_o, wbm_we_o;
    logic [ADDR_W-1:0]     wbm_addr_o;
    logic [DATA_W-1:0]     wbm_data_o;
    logic [DATA_W/8-1:0]   wbm_sel_o;
    logic                  wbm_ack_i;
    logic [DATA_W-1:0]     wbm_data_i;
    logic [1:0]            grant_o;

    modport slave (
        input  m0_cycle_i, m0_strobe_i, m0_we_i, m0_addr_i, m0_data_i, m0_sel_i,
        input  m1_cycle_i, m1_strobe_i, m1_we_i, m1_addr_i, m1_data_i, m1_sel_i,
        input  wbm_ack_i, wbm_data_i,
        output m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m_data_o,
        output wbm_cycle_o, wbm_strobe_o, wbm_we_o, wbm_addr_o, wbm_data_o, wbm_sel_o,
        output grant_o
    );

    modport master (
        output m0_cycle_i, m0_strobe_i, m0_we_i, m0_addr_i, m0_data_i, m0_sel_i,
        output m1_cycle_i, m1_strobe_i, m1_we_i, m1_addr_i, m1_data_i, m1_sel_i,
        output wbm_ack_i, wbm_data_i,
        input  m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m_data_o,
        input  wbm_cycle_o, wbm_strobe_o, wbm_we_o, wbm_addr_o, wbm_data_o, wbm_sel_o,
        input  grant_o
    );

endinterface

// File: rtl/wbm_arbiter_rr.sv
// wbm_arbiter_rr: 2-way round-robin picker, one-hot {m1,m0} grant from requests and last grantee
module wbm_arbiter_rr (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    // a tie goes to whichever master was not served last (i_last=1 means m1)
    always_comb o_grant = &i_req ? (i_last ? 2'b01 : 2'b10) : i_req;

endmodule

// File: rtl/wbm_arbiter.sv
// wbm_arbiter: round-robin, cycle-locked arbiter for two Wishbone masters with a hung-transfer watchdog
module wbm_arbiter
    import wbm_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11
) (
    input  logic         sys_clock_i,
    input  logic         sys_reset_l_i,
    wbm_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT_CYC == 0 ? 0 : TIMEOUT_CYC - 1);

    wbarb_state_t     r_state;
    logic [1:0]       r_grant;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_pick;
    logic             w_gcyc, w_en, w_stb, w_tmo;

    wbm_arbiter_rr u_rr (
        .i_req   ({bus.m1_cycle_i, bus.m0_cycle_i}),
        .i_last  (r_last),
        .o_grant (w_pick)
    );

    // bus is live only in BUSY while the grantee still holds cycle; timeout fires on the last unacked strobe cycle
    always_comb begin
        w_gcyc = r_grant[1] ? bus.m1_cycle_i : bus.m0_cycle_i;
        w_en   = (r_state == WBARB_BUSY) && w_gcyc;
        w_stb  = w_en && (r_grant[1] ? bus.m1_strobe_i : bus.m0_strobe_i);
        w_tmo  = (TIMEOUT_CYC != 0) && w_stb && !bus.wbm_ack_i && (r_cnt == LIM);
    end

    assign bus.wbm_cycle_o  = w_en;
    assign bus.wbm_strobe_o = w_stb;
    assign bus.wbm_we_o     = w_en && (r_grant[1] ? bus.m1_we_i : bus.m0_we_i);
    assign bus.wbm_addr_o   = w_en ? (r_grant[1] ? bus.m1_addr_i : bus.m0_addr_i) : '0;
    assign bus.wbm_data_o   = w_en ? (r_grant[1] ? bus.m1_data_i : bus.m0_data_i) : '0;
    assign bus.wbm_sel_o    = w_en ? (r_grant[1] ? bus.m1_sel_i : bus.m0_sel_i) : '0;
    assign bus.m0_ack_o     = w_en && r_grant[0] && bus.wbm_ack_i;
    assign bus.m1_ack_o     = w_en && r_grant[1] && bus.wbm_ack_i;
    assign bus.m0_err_o     = (r_state == WBARB_ERR) && r_grant[0];
    assign bus.m1_err_o     = (r_state == WBARB_ERR) && r_grant[1];
    assign bus.m_data_o     = bus.wbm_data_i;
    assign bus.grant_o      = r_grant;

    // arbitration FSM: grant in IDLE, lock while grantee holds cycle, one-cycle ERR on watchdog expiry
    always_ff @(posedge sys_clock_i or negedge sys_reset_l_i) begin
        if (!sys_reset_l_i) begin
            r_state <= WBARB_IDLE;
            r_grant <= 2'b00;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                WBARB_IDLE: begin
                    if (|w_pick) begin
                        r_state <= WBARB_BUSY;
                        r_grant <= w_pick;
                    end
                end
                WBARB_BUSY: begin
                    if (!w_gcyc) begin
                        r_state <= WBARB_IDLE;
                        r_grant <= 2'b00;
                        r_last  <= r_grant[1];
                    end else if (w_tmo) begin
                        r_state <= WBARB_ERR;
                    end
                    r_cnt <= (TIMEOUT_CYC == 0 || !w_stb || bus.wbm_ack_i || w_tmo) ? '0 :
                             (&r_cnt ? r_cnt : r_cnt + CNT_W'(1));
                end
                default: begin
                    r_state <= WBARB_IDLE;
                    r_grant <= 2'b00;
                    r_last  <= r_grant[1];
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbm_arbiter.sv
// tb_wbm_arbiter: random multi-master traffic against a transaction-level round-robin model, plus watchdog and reset cases
module tb_wbm_arbiter;
    import wbm_arbiter_pkg::*;

    localparam int SW = WB_DATA_WIDTH / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wbm_arbiter_if ifa ();
    wbm_arbiter_if ifz ();

    wbm_arbiter #(.TIMEOUT_CYC(8), .CNT_W(11)) dut_a (
        .sys_clock_i   (clk),
        .sys_reset_l_i (rst_n),
        .bus           (ifa.slave)
    );

    wbm_arbiter #(.TIMEOUT_CYC(0), .CNT_W(11)) dut_z (
        .sys_clock_i   (clk),
        .sys_reset_l_i (rst_n),
        .bus           (ifz.slave)
    );

    int checks = 0;
    int failures = 0;

    // model state: who was served last, outstanding requests and their payloads
    int                       last_srv = 1;
    bit                       pend [2];
    logic [WB_ADDR_WIDTH-1:0] p_addr [2];
    logic [WB_DATA_WIDTH-1:0] p_data [2];
    logic [SW-1:0]            p_sel [2];
    logic                     p_we [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic cyc, input logic stb);
        if (m == 0) begin
            ifa.m0_cycle_i = cyc; ifa.m0_strobe_i = stb; ifa.m0_we_i = p_we[0];
            ifa.m0_addr_i = p_addr[0]; ifa.m0_data_i = p_data[0]; ifa.m0_sel_i = p_sel[0];
        end else begin
            ifa.m1_cycle_i = cyc; ifa.m1_strobe_i = stb; ifa.m1_we_i = p_we[1];
            ifa.m1_addr_i = p_addr[1]; ifa.m1_data_i = p_data[1]; ifa.m1_sel_i = p_sel[1];
        end
    endtask

    task automatic new_req(input int m);
        p_addr[m] = $urandom;
        p_data[m] = {$urandom, $urandom};
        p_sel[m]  = SW'($urandom);
        p_we[m]   = 1'($urandom);
        pend[m]   = 1'b1;
        drive(m, 1'b1, 1'b1);
    endtask

    // round-robin rule: a lone requester wins; on a tie the master not served last wins
    function automatic int pick();
        if (pend[0] && pend[1]) return 1 - last_srv;
        return pend[1] ? 1 : 0;
    endfunction

    function automatic logic ack_of(input int m);
        return m == 1 ? ifa.m1_ack_o : ifa.m0_ack_o;
    endfunction

    function automatic logic [63:0] onehot(input int m);
        return m == 1 ? 64'd2 : 64'd1;
    endfunction

    // one full transaction of the predicted winner: grant, 1-4 beats with random ack latency, release
    task automatic serve();
        int w;
        int beats;
        logic [WB_DATA_WIDTH-1:0] rd;
        w = pick();
        beats = $urandom_range(1, 4);
        @(posedge clk); #1;
        chk("grant", 64'(ifa.grant_o), onehot(w));
        chk("bus_cyc", 64'(ifa.wbm_cycle_o), 64'd1);
        chk("bus_addr", 64'(ifa.wbm_addr_o), 64'(p_addr[w]));
        chk("bus_data", 64'(ifa.wbm_data_o), 64'(p_data[w]));
        chk("bus_sel", 64'(ifa.wbm_sel_o), 64'(p_sel[w]));
        chk("bus_we", 64'(ifa.wbm_we_o), 64'(p_we[w]));
        for (int b = 0; b < beats; b++) begin
            int lat;
            lat = $urandom_range(0, 4);
            for (int k = 0; k <= lat; k++) begin
                @(negedge clk);
                rd = {$urandom, $urandom};
                ifa.wbm_ack_i = (k == lat);
                ifa.wbm_data_i = rd;
                #1;
                chk("ack_win", 64'(ack_of(w)), 64'(k == lat));
                chk("ack_lose", 64'(ack_of(1 - w)), 64'd0);
                if (k == lat) chk("rdata", 64'(ifa.m_data_o), 64'(rd));
            end
        end
        @(negedge clk);
        ifa.wbm_ack_i = 1'b0;
        pend[w] = 1'b0;
        drive(w, 1'b0, 1'b0);
        #1;
        chk("drop_cyc", 64'(ifa.wbm_cycle_o), 64'd0);
        chk("drop_grant", 64'(ifa.grant_o), onehot(w));
        last_srv = w;
        @(posedge clk); #1;
        chk("idle_grant", 64'(ifa.grant_o), 64'd0);
    endtask

    initial begin
        logic seen;
        for (int m = 0; m < 2; m++) begin
            p_addr[m] = '0; p_data[m] = '0; p_sel[m] = '0; p_we[m] = 1'b0; pend[m] = 1'b0;
            drive(m, 1'b0, 1'b0);
        end
        ifa.wbm_ack_i = 1'b0; ifa.wbm_data_i = '0;
        ifz.m0_cycle_i = 1'b0; ifz.m0_strobe_i = 1'b0; ifz.m0_we_i = 1'b0;
        ifz.m0_addr_i = '0; ifz.m0_data_i = '0; ifz.m0_sel_i = '0;
        ifz.m1_cycle_i = 1'b0; ifz.m1_strobe_i = 1'b0; ifz.m1_we_i = 1'b0;
        ifz.m1_addr_i = '0; ifz.m1_data_i = '0; ifz.m1_sel_i = '0;
        ifz.wbm_ack_i = 1'b0; ifz.wbm_data_i = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 64'(ifa.grant_o), 64'd0);
        chk("rst_cyc", 64'(ifa.wbm_cycle_o), 64'd0);
        chk("rst_stb", 64'(ifa.wbm_strobe_o), 64'd0);
        chk("rst_err", 64'({ifa.m1_err_o, ifa.m0_err_o}), 64'd0);
        chk("rst_ack", 64'({ifa.m1_ack_o, ifa.m0_ack_o}), 64'd0);

        // simultaneous requests out of reset: m0 first, then m1
        @(negedge clk);
        rst_n = 1'b1;
        new_req(0);
        new_req(1);
        serve();

        repeat (30) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) if (!pend[m] && $urandom_range(0, 1) == 1) new_req(m);
            if (!pend[0] && !pend[1]) new_req($urandom_range(0, 1));
            serve();
        end
        while (pend[0] || pend[1]) begin
            @(negedge clk);
            serve();
        end

        // watchdog: m1 strobes with no ack, error exactly 8 cycles after strobe
        @(negedge clk);
        new_req(1);
        @(posedge clk); #1;
        chk("to_grant", 64'(ifa.grant_o), 64'd2);
        repeat (7) begin
            @(posedge clk); #1;
            chk("to_noerr", 64'(ifa.m1_err_o), 64'd0);
            chk("to_cyc", 64'(ifa.wbm_cycle_o), 64'd1);
        end
        @(posedge clk); #1;
        chk("to_err", 64'(ifa.m1_err_o), 64'd1);
        chk("to_err_other", 64'(ifa.m0_err_o), 64'd0);
        chk("to_err_cyc", 64'(ifa.wbm_cycle_o), 64'd0);
        chk("to_err_stb", 64'(ifa.wbm_strobe_o), 64'd0);
        @(negedge clk);
        pend[1] = 1'b0;
        drive(1, 1'b0, 1'b0);
        last_srv = 1;
        @(posedge clk); #1;
        chk("to_after_err", 64'(ifa.m1_err_o), 64'd0);
        chk("to_idle", 64'(ifa.grant_o), 64'd0);

        // ack on the 8th strobe cycle beats the timeout
        @(negedge clk);
        new_req(0);
        @(posedge clk); #1;
        chk("ta_grant", 64'(ifa.grant_o), 64'd1);
        repeat (7) begin
            @(posedge clk); #1;
            chk("ta_noerr", 64'(ifa.m0_err_o), 64'd0);
        end
        @(negedge clk);
        ifa.wbm_ack_i = 1'b1;
        #1;
        chk("ta_ack", 64'(ifa.m0_ack_o), 64'd1);
        @(posedge clk); #1;
        chk("ta_no_err", 64'(ifa.m0_err_o), 64'd0);
        chk("ta_still_busy", 64'(ifa.wbm_cycle_o), 64'd1);
        @(negedge clk);
        ifa.wbm_ack_i = 1'b0;
        pend[0] = 1'b0;
        drive(0, 1'b0, 1'b0);
        last_srv = 0;
        @(posedge clk); #1;
        chk("ta_idle", 64'(ifa.grant_o), 64'd0);

        // asynchronous reset in the middle of a BUSY transfer
        @(negedge clk);
        new_req(0);
        new_req(1);
        @(posedge clk); #1;
        chk("rb_grant", 64'(ifa.grant_o), onehot(pick()));
        @(negedge clk);
        ifa.wbm_ack_i = 1'b1;
        #1;
        chk("rb_ack", 64'(ifa.m1_ack_o), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rb_grant0", 64'(ifa.grant_o), 64'd0);
        chk("rb_cyc0", 64'(ifa.wbm_cycle_o), 64'd0);
        chk("rb_stb0", 64'(ifa.wbm_strobe_o), 64'd0);
        chk("rb_ack0", 64'({ifa.m1_ack_o, ifa.m0_ack_o}), 64'd0);
        chk("rb_addr0", 64'(ifa.wbm_addr_o), 64'd0);
        ifa.wbm_ack_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_srv = 1;
        @(posedge clk); #1;
        chk("rb_tie_m0", 64'(ifa.grant_o), onehot(pick()));
        @(negedge clk);
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("rb_idle", 64'(ifa.grant_o), 64'd0);

        // watchdog disabled: long unacked strobe never errors and keeps the grant
        @(negedge clk);
        ifz.m0_addr_i = $urandom;
        ifz.m0_cycle_i = 1'b1;
        ifz.m0_strobe_i = 1'b1;
        @(posedge clk); #1;
        chk("wd0_grant", 64'(ifz.grant_o), 64'd1);
        seen = 1'b0;
        repeat (5000) begin
            @(posedge clk); #1;
            if (ifz.m0_err_o || !ifz.wbm_cycle_o || ifz.grant_o != 2'b01) seen = 1'b1;
        end
        chk("wd0_never_err", 64'(seen), 64'd0);
        chk("wd0_grant_held", 64'(ifz.grant_o), 64'd1);
        @(negedge clk);
        ifz.m0_cycle_i = 1'b0;
        ifz.m0_strobe_i = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
